// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command opcodes and host FSM states shared by the command host and bridge
package uart_cmd_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ = 8'h72;
  typedef enum logic [2:0] {IDLE, TX_BYTE, TX_HOLD, RX_WAIT, DONE} host_state_t;
endpackage

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: serialises one read/write command onto a UART byte handshake and reports its completion
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int TimeoutCycles = 1_000_000,
  parameter int TxHoldoff = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_write,
  input  logic [7:0] i_cmd_addr,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic [7:0] o_tx_data,
  output logic       o_tx_req,
  input  logic       i_tx_rdy,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_rdy,
  output logic       o_rx_req
);
  localparam int CW = $clog2(TimeoutCycles + 1);
  host_state_t r_state, w_next;
  logic [1:0] r_idx, w_idx;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_ready, r_write, r_tx_req, r_rx_req, r_rsp_valid, r_rsp_err;
  logic [7:0] r_addr, r_data, r_tx_data, r_rsp_data, w_byte;
  logic w_accept, w_last, w_tx_fire, w_rx_fire, w_rsp_fire, w_rsp_err;
  assign o_cmd_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err = r_rsp_err;
  assign o_tx_data = r_tx_data;
  assign o_tx_req = r_tx_req;
  assign o_rx_req = r_rx_req;
  assign w_accept = r_state == IDLE && r_ready && i_cmd_valid;
  assign w_byte = r_idx == 2'd0 ? (r_write ? CMD_WRITE : CMD_READ) : r_idx == 2'd1 ? r_addr : r_data;
  assign w_last = r_idx == (r_write ? 2'd2 : 2'd1);
  // Any received byte is consumed in every state; it only becomes a response in RX_WAIT.
  assign w_rx_fire = i_rx_rdy && !r_rx_req;
  always_comb begin
    w_next = r_state;
    w_idx = r_idx;
    w_cnt = r_cnt;
    w_tx_fire = 1'b0;
    w_rsp_fire = 1'b0;
    w_rsp_err = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_accept ? TX_BYTE : IDLE;
        w_idx = w_accept ? 2'd0 : r_idx;
      end
      TX_BYTE: begin
        w_tx_fire = i_tx_rdy;
        w_next = i_tx_rdy ? TX_HOLD : TX_BYTE;
        w_cnt = '0;
      end
      TX_HOLD: begin
        if (r_cnt == CW'(TxHoldoff - 1)) begin
          w_idx = r_idx + 2'd1;
          w_cnt = '0;
          w_next = !w_last ? TX_BYTE : r_write ? DONE : RX_WAIT;
          w_rsp_fire = w_last && r_write;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      RX_WAIT: begin
        w_rsp_fire = w_rx_fire || r_cnt == CW'(TimeoutCycles - 1);
        w_rsp_err = !w_rx_fire && w_rsp_fire;
        w_next = w_rsp_fire ? IDLE : RX_WAIT;
        w_cnt = r_cnt == '1 ? r_cnt : r_cnt + CW'(1);
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_tx_req <= 1'b0;
      r_tx_data <= '0;
      r_rx_req <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx;
      r_cnt <= w_cnt;
      r_ready <= w_next == IDLE;
      if (w_accept) begin
        r_write <= i_cmd_write;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
      end
      r_tx_req <= w_tx_fire;
      r_tx_data <= w_tx_fire ? w_byte : '0;
      r_rx_req <= w_rx_fire;
      r_rsp_valid <= w_rsp_fire;
      r_rsp_err <= w_rsp_err;
      if (w_rsp_fire) r_rsp_data <= (r_write || w_rsp_err) ? '0 : i_rx_data;
    end
  end
endmodule

// File: tb/tb_uart_cmd_host.sv
// tb_uart_cmd_host: table-driven and randomized checks of uart_cmd_host against a transaction-level model
module tb_uart_cmd_host;
  import uart_cmd_pkg::*;
  localparam int TO = 120;
  localparam int H = 2;
  logic i_clk = 0, i_rst = 1, i_cmd_valid = 0, i_cmd_write = 0, i_tx_rdy = 1, i_rx_rdy = 0;
  logic [7:0] i_cmd_addr = 0, i_cmd_data = 0, i_rx_data = 0;
  logic o_cmd_ready, o_rsp_valid, o_rsp_err, o_tx_req, o_rx_req;
  logic [7:0] o_rsp_data, o_tx_data;
  int cyc = 0, tests = 0, fails = 0;

  uart_cmd_host #(.TimeoutCycles(TO), .TxHoldoff(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_tx_data(o_tx_data), .o_tx_req(o_tx_req), .i_tx_rdy(i_tx_rdy),
    .i_rx_data(i_rx_data), .i_rx_rdy(i_rx_rdy), .o_rx_req(o_rx_req)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit wr;
    logic [7:0] a, d, rb;
    int dly, stall;
    logic [7:0] ed;
    bit ee;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_tx_data, o_tx_req, o_rx_req};
  endfunction

  // dly < 0 means no response byte is ever offered; dly counts clocks from entering the response wait
  task automatic run_cmd(input bit wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rb,
                         input int dly, input int stall, input bit rnd_tx,
                         input logic [7:0] ed, input bit ee, input string nm);
    logic [7:0] exp_b[$], got[$];
    logic [7:0] got_d;
    bit seen, pres, prev_rdy, prev_req, prev_rx, got_e;
    int p, c0, vcyc, nrx, viol, stall_left, q1, q2, n, exp_at;
    exp_b.push_back(wr ? CMD_WRITE : CMD_READ);
    exp_b.push_back(a);
    if (wr) exp_b.push_back(d);
    {seen, pres, prev_req, prev_rx, got_e} = '0;
    got_d = 0;
    {p, vcyc, q1, q2} = {-1, -1, -1, -1};
    {nrx, viol, stall_left, n} = '0;
    @(negedge i_clk);
    while (!o_cmd_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk({nm, "_ready"}, o_cmd_ready, 1);
    i_cmd_valid = 1;
    i_cmd_write = wr;
    i_cmd_addr = a;
    i_cmd_data = d;
    c0 = cyc;
    prev_rdy = i_tx_rdy;
    for (int k = 0; k < 2000; k++) begin
      @(negedge i_clk);
      if (k == 0) begin
        i_cmd_valid = 0;
        i_cmd_write = 1'($urandom_range(0, 1));
        i_cmd_addr = 8'($urandom);
        i_cmd_data = 8'($urandom);
        chk({nm, "_ready_drop"}, o_cmd_ready, 0);
      end
      if (prev_req && o_tx_req) viol++;
      if (prev_rx && o_rx_req) viol++;
      if (!o_tx_req && o_tx_data != 0) viol++;
      if (o_tx_req && !prev_rdy) viol++;
      if (o_rx_req && !i_rx_rdy) viol++;
      prev_req = o_tx_req;
      prev_rx = o_rx_req;
      if (o_tx_req) begin
        got.push_back(o_tx_data);
        if (got.size() == 1) q1 = cyc;
        if (got.size() == 2) q2 = cyc;
        if (got.size() == exp_b.size()) p = cyc;
        if (got.size() == 1 && stall > 0) stall_left = stall;
      end
      if (o_rx_req) begin
        nrx++;
        i_rx_rdy = 0;
      end
      if (o_rsp_valid) begin
        if (seen) viol++;
        seen = 1;
        vcyc = cyc;
        got_d = o_rsp_data;
        got_e = o_rsp_err;
      end
      if (p >= 0 && !wr && dly >= 0 && !pres && cyc == p + H + dly) begin
        pres = 1;
        i_rx_rdy = 1;
        i_rx_data = rb;
      end
      if (stall_left > 0) begin
        i_tx_rdy = 0;
        stall_left--;
      end else i_tx_rdy = rnd_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
      prev_rdy = i_tx_rdy;
      if (seen && !i_rx_rdy && (wr || dly < 0 || pres)) break;
    end
    exp_at = wr ? p + H : (dly >= 0 && dly < TO) ? p + H + dly + 1 : p + H + TO;
    chk({nm, "_rsp_seen"}, seen, 1);
    chk({nm, "_nbytes"}, got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) chk({nm, "_byte"}, got[i], exp_b[i]);
    chk({nm, "_rsp_cycle"}, vcyc, exp_at);
    chk({nm, "_rsp_data"}, got_d, ed);
    chk({nm, "_rsp_err"}, got_e, ee);
    chk({nm, "_rx_pulses"}, nrx, (!wr && dly >= 0) ? 1 : 0);
    chk({nm, "_protocol"}, viol, 0);
    if (wr && stall == 0 && !rnd_tx) chk({nm, "_latency"}, vcyc - c0, 3 * (1 + H) + 1);
    if (stall > 0) chk({nm, "_stall_gap"}, q2 - q1, stall + 1);
    @(negedge i_clk);
    chk({nm, "_pulse_end"}, o_rsp_valid, 0);
    chk({nm, "_held"}, o_rsp_data, ed);
  endtask

  initial begin
    vec_t tbl[7];
    bit wr, ok;
    int dly;
    logic [7:0] rb;
    tbl[0] = '{1, 8'h12, 8'hA5, 8'h00, -1, 0, 8'h00, 0};
    tbl[1] = '{0, 8'h34, 8'h00, 8'h5C, 100, 0, 8'h5C, 0};
    tbl[2] = '{0, 8'h56, 8'h00, 8'h00, -1, 0, 8'h00, 1};
    tbl[3] = '{1, 8'h9A, 8'h3C, 8'h00, -1, 20, 8'h00, 0};
    tbl[4] = '{0, 8'h01, 8'h00, 8'hC3, TO - 1, 0, 8'hC3, 0};
    tbl[5] = '{0, 8'h02, 8'h00, 8'h7E, TO, 0, 8'h00, 1};
    tbl[6] = '{0, 8'hFF, 8'h00, 8'h11, 0, 0, 8'h11, 0};
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", outs(), 0);
    i_rst = 0;
    @(negedge i_clk);
    chk("reset_ready", o_cmd_ready, 1);
    for (int i = 0; i < 7; i++)
      run_cmd(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rb, tbl[i].dly, tbl[i].stall, 0,
              tbl[i].ed, tbl[i].ee, $sformatf("vec%0d", i));
    // reset while the read opcode is in its holdoff window
    @(negedge i_clk);
    i_cmd_valid = 1;
    i_cmd_write = 0;
    i_cmd_addr = 8'h44;
    @(negedge i_clk);
    i_cmd_valid = 0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge i_clk);
      ok = o_tx_req;
    end
    chk("rst_mid_txreq", ok, 1);
    i_rst = 1;
    @(negedge i_clk);
    chk("rst_mid_outputs", outs(), 0);
    i_rst = 0;
    @(negedge i_clk);
    chk("rst_mid_ready", o_cmd_ready, 1);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      ok = ok | o_tx_req | o_rsp_valid;
    end
    chk("rst_mid_no_resume", ok, 0);
    run_cmd(1, 8'h21, 8'h43, 8'h00, -1, 0, 0, 8'h00, 0, "after_rst");
    // stray byte in IDLE is consumed silently
    i_rx_data = 8'hFF;
    i_rx_rdy = 1;
    ok = 0;
    for (int k = 0; k < 10 && i_rx_rdy; k++) begin
      @(negedge i_clk);
      ok = ok | o_rsp_valid;
      if (o_rx_req) i_rx_rdy = 0;
    end
    chk("stray_drained", i_rx_rdy, 0);
    repeat (3) begin
      @(negedge i_clk);
      ok = ok | o_rsp_valid;
    end
    chk("stray_no_rsp", ok, 0);
    run_cmd(0, 8'h20, 8'h00, 8'h01, 5, 0, 0, 8'h01, 0, "after_stray");
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 4) == 0 ? -1 : $urandom_range(0, TO + 10);
      rb = 8'($urandom);
      run_cmd(wr, 8'($urandom), 8'($urandom), rb, dly, 0, 1,
              (wr || dly < 0 || dly >= TO) ? 8'h00 : rb, !wr && (dly < 0 || dly >= TO),
              $sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
